// File: rtl/mem_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_n
//  Function : N-client line arbiter in front of a single downstream memory
//             port; round-robin or fixed priority, one transaction in flight.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter_n #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32,
    parameter int RR_MODE   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           cl_read,
    input  logic [NUM_PORTS-1:0]           cl_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    cl_address,
    input  logic [NUM_PORTS*LINE_W-1:0]    cl_wdata,
    output logic [NUM_PORTS-1:0]           cl_resp,
    output logic [LINE_W-1:0]              cl_rdata,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [LINE_W-1:0]              mem_wdata,
    input  logic [LINE_W-1:0]              mem_rdata,
    input  logic                           mem_resp,
    output logic                           busy,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_id
);

    localparam int GRANT_W = $clog2(NUM_PORTS);
    localparam logic [GRANT_W-1:0] c_last_port = GRANT_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               state_q,      state_d;
    logic [GRANT_W-1:0]   grant_id_q,   grant_id_d;
    logic [GRANT_W-1:0]   last_grant_q, last_grant_d;
    logic                 write_q,      write_d;
    logic [ADDR_W-1:0]    addr_q,       addr_d;
    logic [LINE_W-1:0]    wdata_q,      wdata_d;

    logic [NUM_PORTS-1:0] w_req_any;
    logic                 w_sel_found;
    logic [GRANT_W-1:0]   w_sel_idx;
    logic [GRANT_W-1:0]   w_cand;
    logic                 w_sel_write;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LINE_W-1:0]    w_sel_wdata;

    assign w_req_any = cl_read | cl_write;

    // Port reached by stepping 'offset' places past 'last', wrapping at NUM_PORTS.
    function automatic logic [GRANT_W-1:0] rr_port(input logic [GRANT_W-1:0] last,
                                                   input int offset);
        int sum;
        sum = int'(last) + offset;
        if (sum >= NUM_PORTS) begin
            sum = sum - NUM_PORTS;
        end
        return GRANT_W'(sum);
    endfunction

    // Candidates are visited in priority order; the first requester wins.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (RR_MODE != 0) begin
                w_cand = rr_port(last_grant_q, k + 1);
            end else begin
                w_cand = GRANT_W'(k);
            end
            if (!w_sel_found && w_req_any[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand;
                w_sel_write = cl_write[w_cand];
                w_sel_addr  = cl_address[w_cand * ADDR_W +: ADDR_W];
                w_sel_wdata = cl_wdata[w_cand * LINE_W +: LINE_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cl_resp      = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_sel_found) begin
                    state_d      = ST_BUSY;
                    grant_id_d   = w_sel_idx;
                    last_grant_d = w_sel_idx;
                    write_d      = w_sel_write;
                    addr_d       = w_sel_addr;
                    wdata_d      = w_sel_wdata;
                end
            end
            ST_BUSY: begin
                // Completion is forwarded in the same cycle it arrives.
                if (mem_resp) begin
                    cl_resp[grant_id_q] = 1'b1;
                    state_d             = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= c_last_port;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy        = (state_q == ST_BUSY);
    assign mem_read    = busy & ~write_q;
    assign mem_write   = busy &  write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign cl_rdata    = mem_rdata;
    assign grant_id    = grant_id_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter_n
//  Function : scoreboard bench for mem_arbiter_n, one round-robin and one
//             fixed-priority instance with a variable-latency memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter_n;

    localparam int N  = 4;
    localparam int LW = 64;
    localparam int AW = 32;

    typedef struct packed {
        logic [0:0]    d;
        logic [1:0]    port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    rd     [2];
    logic [N-1:0]    wr     [2];
    logic [N-1:0]    sticky [2];
    logic [N-1:0]    resp   [2];
    logic [N*AW-1:0] ab     [2];
    logic [N*LW-1:0] wb     [2];
    logic [LW-1:0]   rdata  [2];
    logic [LW-1:0]   mrdata [2];
    logic [LW-1:0]   mwd    [2];
    logic [AW-1:0]   maddr  [2];
    logic [1:0]      gid    [2];
    logic            mrd    [2];
    logic            mwr    [2];
    logic            mresp  [2];
    logic            stray  [2];
    logic            busy   [2];

    exp_t sb_q[$];
    exp_t cur    [2];
    logic active [2];
    int   rsp_cnt[2];
    int   cnt    [2];
    int   lat;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_n #(.NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) u_rr (
        .clk(clk), .reset_n(rst_n),
        .cl_read(rd[0]), .cl_write(wr[0]), .cl_address(ab[0]), .cl_wdata(wb[0]),
        .cl_resp(resp[0]), .cl_rdata(rdata[0]),
        .mem_read(mrd[0]), .mem_write(mwr[0]), .mem_address(maddr[0]),
        .mem_wdata(mwd[0]), .mem_rdata(mrdata[0]), .mem_resp(mresp[0] | stray[0]),
        .busy(busy[0]), .grant_id(gid[0])
    );

    mem_arbiter_n #(.NUM_PORTS(N), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) u_fx (
        .clk(clk), .reset_n(rst_n),
        .cl_read(rd[1]), .cl_write(wr[1]), .cl_address(ab[1]), .cl_wdata(wb[1]),
        .cl_resp(resp[1]), .cl_rdata(rdata[1]),
        .mem_read(mrd[1]), .mem_write(mwr[1]), .mem_address(maddr[1]),
        .mem_wdata(mwd[1]), .mem_rdata(mrdata[1]), .mem_resp(mresp[1] | stray[1]),
        .busy(busy[1]), .grant_id(gid[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream memory: answers 'lat' cycles after a request appears.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                cnt[d]   = 0;
                mresp[d] = 1'b0;
            end else if (mresp[d]) begin
                mresp[d] = 1'b0;
            end else if (mrd[d] | mwr[d]) begin
                cnt[d]++;
                if (cnt[d] >= lat) begin
                    cnt[d]    = 0;
                    mresp[d]  = 1'b1;
                    mrdata[d] = {maddr[d], ~maddr[d]};
                end
            end
        end
    end

    // Monitor: pops an expectation on each new issue, checks it while busy.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                active[d] = 1'b0;
            end else begin
                if ((mrd[d] | mwr[d]) && !active[d]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: dut %0d granted port %0d, expected none", d, gid[d]);
                    end else begin
                        cur[d]    = sb_q.pop_front();
                        active[d] = 1'b1;
                        chk("issue_dut", 64'(d), 64'(cur[d].d));
                        chk("grant_id", 64'(gid[d]), 64'(cur[d].port));
                    end
                end
                if (active[d]) begin
                    chk("busy", 64'(busy[d]), 64'(1));
                    chk("mem_write", 64'(mwr[d]), 64'(cur[d].wr));
                    chk("mem_read", 64'(mrd[d]), 64'(!cur[d].wr));
                    chk("mem_address", 64'(maddr[d]), 64'(cur[d].addr));
                    chk("mem_wdata", 64'(mwd[d]), 64'(cur[d].wdata));
                end
                if (resp[d] != '0) begin
                    if (!active[d]) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_cl_resp: dut %0d got %0h expected 0", d, resp[d]);
                    end else begin
                        chk("cl_resp", 64'(resp[d]), 64'(1) << cur[d].port);
                        chk("cl_rdata", 64'(rdata[d]), 64'(mrdata[d]));
                    end
                    active[d] = 1'b0;
                    rsp_cnt[d]++;
                    for (int i = 0; i < N; i++) begin
                        if (resp[d][i] && !sticky[d][i]) begin
                            rd[d][i] = 1'b0;
                            wr[d][i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic push(input int d, input int port, input logic w,
                        input logic [AW-1:0] a, input logic [LW-1:0] data);
        exp_t e;
        e.d     = 1'(d);
        e.port  = 2'(port);
        e.wr    = w;
        e.addr  = a;
        e.wdata = data;
        sb_q.push_back(e);
    endtask

    task automatic req(input int d, input int port, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [LW-1:0] data, input logic stk);
        rd[d][port]               = r;
        wr[d][port]               = w;
        ab[d][port*AW +: AW]      = a;
        wb[d][port*LW +: LW]      = data;
        sticky[d][port]           = stk;
    endtask

    task automatic clear_reqs();
        for (int d = 0; d < 2; d++) begin
            rd[d]     = '0;
            wr[d]     = '0;
            sticky[d] = '0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!(sb_q.size() == 0 && !active[0] && !active[1] && !busy[0] && !busy[1] &&
                 rd[0] == '0 && wr[0] == '0 && rd[1] == '0 && wr[1] == '0) && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d expectations left, required 0 within %0d cycles",
                     name, sb_q.size(), budget);
            sb_q.delete();
            clear_reqs();
        end
    endtask

    task automatic wait_rsp(input string name, input int d, input int target, input int budget);
        int n = 0;
        while (rsp_cnt[d] < target && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: responses %0d, required %0d", name, rsp_cnt[d], target);
        end
    endtask

    task automatic wait_active(input string name, input int d, input int budget);
        int n = 0;
        while (!active[d] && n < budget) begin
            step(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no issue seen, required one within %0d cycles", name, budget);
        end
    endtask

    task automatic chk_reset_state(input string tag, input int d);
        chk({tag, "_busy"}, 64'(busy[d]), 64'(0));
        chk({tag, "_mem_read"}, 64'(mrd[d]), 64'(0));
        chk({tag, "_mem_write"}, 64'(mwr[d]), 64'(0));
        chk({tag, "_cl_resp"}, 64'(resp[d]), 64'(0));
        chk({tag, "_grant_id"}, 64'(gid[d]), 64'(0));
        chk({tag, "_mem_address"}, 64'(maddr[d]), 64'(0));
        chk({tag, "_mem_wdata"}, 64'(mwd[d]), 64'(0));
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        lat   = 1;
        for (int d = 0; d < 2; d++) begin
            rd[d] = '0; wr[d] = '0; sticky[d] = '0; ab[d] = '0; wb[d] = '0;
            mrdata[d] = '0; mresp[d] = 1'b0; stray[d] = 1'b0;
            active[d] = 1'b0; rsp_cnt[d] = 0; cnt[d] = 0;
        end
        step(2);
        chk_reset_state("reset_rr", 0);
        chk_reset_state("reset_fx", 1);
        rst_n = 1'b1;
        step(1);

        // Simultaneous read on port 0 and write on port 1: port 0 first.
        push(0, 0, 1'b0, 32'h100, 64'h0123_4567_89AB_CDEF);
        push(0, 1, 1'b1, 32'h200, 64'hFEDC_BA98_7654_3210);
        req(0, 0, 1'b1, 1'b0, 32'h100, 64'h0123_4567_89AB_CDEF, 1'b0);
        req(0, 1, 1'b0, 1'b1, 32'h200, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_done("rr_pair", 40);

        // All four ports requesting continuously after reset: 0,1,2,3,0.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        push(0, 0, 1'b0, 32'h1000, 64'h10);
        push(0, 1, 1'b0, 32'h1040, 64'h11);
        push(0, 2, 1'b0, 32'h1080, 64'h12);
        push(0, 3, 1'b0, 32'h10C0, 64'h13);
        push(0, 0, 1'b0, 32'h1000, 64'h10);
        base = rsp_cnt[0];
        for (int p = 0; p < N; p++) begin
            req(0, p, 1'b1, 1'b0, 32'h1000 + 32'(p) * 32'h40, 64'h10 + 64'(p), 1'b1);
        end
        wait_rsp("rr_all", 0, base + 5, 60);
        rd[0] = '0; wr[0] = '0; sticky[0] = '0;
        wait_done("rr_all", 20);

        // Address changes mid-transaction must not reach the memory side.
        lat = 3;
        push(0, 1, 1'b0, 32'h40, 64'h3333_0000_3333_0000);
        req(0, 1, 1'b1, 1'b0, 32'h40, 64'h3333_0000_3333_0000, 1'b0);
        wait_active("addr_hold", 0, 10);
        step(1);
        ab[0][1*AW +: AW] = 32'h80;
        wait_done("addr_hold", 20);

        // Read and write together: only the write is issued.
        lat = 2;
        push(0, 2, 1'b1, 32'h2C0, 64'hA5A5_A5A5_A5A5_A5A5);
        req(0, 2, 1'b1, 1'b1, 32'h2C0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
        wait_done("rw_both", 20);

        // Reset in the middle of a long transaction.
        lat = 5;
        push(0, 3, 1'b0, 32'h3C0, 64'h5555_5555_5555_5555);
        req(0, 3, 1'b1, 1'b0, 32'h3C0, 64'h5555_5555_5555_5555, 1'b0);
        wait_active("abort", 0, 10);
        step(2);
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset", 0);
        rd[0] = '0; wr[0] = '0;
        step(1);
        rst_n = 1'b1;
        lat   = 1;
        step(1);
        stray[0] = 1'b1;
        #1;
        chk("stray_cl_resp", 64'(resp[0]), 64'(0));
        step(1);
        stray[0] = 1'b0;
        chk("stray_busy", 64'(busy[0]), 64'(0));
        push(0, 0, 1'b0, 32'h300, 64'h0C0C);
        push(0, 2, 1'b0, 32'h320, 64'h2C2C);
        req(0, 0, 1'b1, 1'b0, 32'h300, 64'h0C0C, 1'b0);
        req(0, 2, 1'b1, 1'b0, 32'h320, 64'h2C2C, 1'b0);
        wait_done("after_reset", 30);

        // Fixed priority: port 1 keeps winning until it lets go.
        push(1, 1, 1'b0, 32'h500, 64'h5151);
        push(1, 1, 1'b0, 32'h500, 64'h5151);
        push(1, 1, 1'b0, 32'h500, 64'h5151);
        push(1, 3, 1'b1, 32'h700, 64'h7373);
        base = rsp_cnt[1];
        req(1, 1, 1'b1, 1'b0, 32'h500, 64'h5151, 1'b1);
        req(1, 3, 1'b0, 1'b1, 32'h700, 64'h7373, 1'b0);
        wait_rsp("fixed", 1, base + 3, 40);
        rd[1][1] = 1'b0;
        sticky[1][1] = 1'b0;
        wait_done("fixed", 30);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
